// File: rtl/movement.sv
// Motion and door controller for a 3-floor elevator using a SCAN service policy.
// Optional macro DOOR_HOLD_EN: a current-floor request during DOOR restarts the door timer.
module movement #(
  parameter int FLOOR_TICKS = 2,
  parameter int DOOR_TICKS  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       My_Clock,
  input  logic [2:0] interior_panel,
  input  logic [2:0] exterior_panel,
  output logic [1:0] engine,
  output logic [2:0] doors
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DOOR = 2'd3
  } state_t;

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DOWN = 2'b10;
  localparam int MAX_T = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int CW    = $clog2(MAX_T + 1);

  function automatic logic [2:0] onehot(input logic [1:0] f);
    case (f)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] above_mask(input logic [1:0] f);
    case (f)
      2'd0:    above_mask = 3'b110;
      2'd1:    above_mask = 3'b100;
      default: above_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_mask(input logic [1:0] f);
    case (f)
      2'd1:    below_mask = 3'b001;
      2'd2:    below_mask = 3'b011;
      default: below_mask = 3'b000;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      floor_q, floor_d;
  logic [2:0]      pending_q, pending_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_up_q, last_up_d;
  logic [1:0]      engine_q, engine_d;
  logic [2:0]      doors_q, doors_d;

  logic [2:0]      req_s, pend_all_s, here_s, arr_hot_s;
  logic [1:0]      arr_floor_s;
  logic [CW-1:0]   cnt_inc_s;
  logic            has_above_s, has_below_s, go_up_s, go_down_s, beyond_s;

  // Request merge and direction decision terms
  always_comb begin
    req_s       = interior_panel | exterior_panel;
    pend_all_s  = pending_q | req_s;
    here_s      = onehot(floor_q);
    cnt_inc_s   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    has_above_s = |(pend_all_s & above_mask(floor_q));
    has_below_s = |(pend_all_s & below_mask(floor_q));
    go_up_s     = has_above_s && (last_up_q || !has_below_s);
    go_down_s   = has_below_s && !go_up_s;
    if (state_q == S_DOWN) begin
      arr_floor_s = floor_q - 2'd1;
      beyond_s    = |(pend_all_s & below_mask(arr_floor_s));
    end else begin
      arr_floor_s = floor_q + 2'd1;
      beyond_s    = |(pend_all_s & above_mask(arr_floor_s));
    end
    arr_hot_s = onehot(arr_floor_s);
  end

  // Next-state logic; without a My_Clock tick everything but request capture holds
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    pending_d = pend_all_s;
    cnt_d     = cnt_q;
    last_up_d = last_up_q;
    engine_d  = engine_q;
    doors_d   = doors_q;
    case (state_q)
      S_IDLE: begin
        if (!My_Clock) begin
          state_d = S_IDLE;
        end else if (|(pend_all_s & here_s)) begin
          state_d   = S_DOOR;
          pending_d = pend_all_s & ~here_s;
          doors_d   = here_s;
          engine_d  = ENG_STOP;
          cnt_d     = '0;
        end else if (go_up_s) begin
          state_d   = S_UP;
          engine_d  = ENG_UP;
          last_up_d = 1'b1;
          cnt_d     = '0;
        end else if (go_down_s) begin
          state_d   = S_DOWN;
          engine_d  = ENG_DOWN;
          last_up_d = 1'b0;
          cnt_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UP, S_DOWN: begin
        if (!My_Clock) begin
          cnt_d = cnt_q;
        end else if (cnt_inc_s == CW'(FLOOR_TICKS)) begin
          floor_d = arr_floor_s;
          cnt_d   = '0;
          if (|(pend_all_s & arr_hot_s)) begin
            state_d   = S_DOOR;
            pending_d = pend_all_s & ~arr_hot_s;
            engine_d  = ENG_STOP;
            doors_d   = arr_hot_s;
          end else if (beyond_s) begin
            state_d = state_q;
          end else begin
            state_d  = S_IDLE;
            engine_d = ENG_STOP;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_DOOR: begin
        // A press for the open floor is swallowed rather than queued for a reopen
        pending_d = pend_all_s & ~here_s;
`ifdef DOOR_HOLD_EN
        if (|(req_s & here_s)) begin
          cnt_d = '0;
        end else
`endif
        if (!My_Clock) begin
          cnt_d = cnt_q;
        end else if (cnt_inc_s == CW'(DOOR_TICKS)) begin
          state_d = S_IDLE;
          doors_d = 3'b000;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d  = S_IDLE;
        engine_d = ENG_STOP;
        doors_d  = 3'b000;
        cnt_d    = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      floor_q   <= 2'd0;
      pending_q <= 3'b000;
      cnt_q     <= '0;
      last_up_q <= 1'b1;
      engine_q  <= ENG_STOP;
      doors_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      last_up_q <= last_up_d;
      engine_q  <= engine_d;
      doors_q   <= doors_d;
    end
  end

  assign engine = engine_q;
  assign doors  = doors_q;

endmodule

// File: tb/tb_movement.sv
// Directed bench for movement: position/countdown model checked every cycle plus literal checkpoints.
module tb_movement;

  localparam int FT = 2;
  localparam int DT = 3;
`ifdef DOOR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic       My_Clock;
  logic [2:0] interior_panel;
  logic [2:0] exterior_panel;
  logic [1:0] engine;
  logic [2:0] doors;

  int total = 0;
  int bad   = 0;

  movement #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .CLK(CLK), .RST(RST), .My_Clock(My_Clock),
    .interior_panel(interior_panel), .exterior_panel(exterior_panel),
    .engine(engine), .doors(doors)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: cab position in travel ticks, signed direction, door countdown.
  typedef struct {
    int         pos;
    int         dir;
    int         last;
    logic [2:0] pend;
    int         door_left;
  } ms_t;

  ms_t m;
  bit  chk_en = 1'b0;

  function automatic bit any_beyond(logic [2:0] p, int fl, int dir);
    bit r = 1'b0;
    for (int f = 0; f < 3; f++)
      if (p[f] && ((dir > 0 && f > fl) || (dir < 0 && f < fl))) r = 1'b1;
    return r;
  endfunction

  function automatic ms_t model_next(ms_t s, logic rst, logic tick, logic [2:0] req);
    ms_t n;
    int  fl;
    int  left;
    n = s;
    if (rst) begin
      n.pos = 0; n.dir = 0; n.last = 1; n.pend = 3'b000; n.door_left = 0;
      return n;
    end
    n.pend = s.pend | req;
    fl = s.pos / FT;
    if (s.door_left > 0) begin
      n.pend[fl] = 1'b0;
      left = s.door_left;
      if (tick) left = left - 1;
`ifdef DOOR_HOLD_EN
      if (req[fl]) left = DT;
`endif
      n.door_left = left;
    end else if (s.dir != 0) begin
      if (tick) begin
        n.pos = s.pos + s.dir;
        if (n.pos % FT == 0) begin
          fl = n.pos / FT;
          if (n.pend[fl]) begin
            n.pend[fl] = 1'b0; n.dir = 0; n.door_left = DT;
          end else if (!any_beyond(n.pend, fl, s.dir)) begin
            n.dir = 0;
          end
        end
      end
    end else if (tick) begin
      if (n.pend[fl]) begin
        n.pend[fl] = 1'b0; n.door_left = DT;
      end else if (any_beyond(n.pend, fl, 1) && (s.last == 1 || !any_beyond(n.pend, fl, -1))) begin
        n.dir = 1; n.last = 1;
      end else if (any_beyond(n.pend, fl, -1)) begin
        n.dir = -1; n.last = -1;
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] exp_engine(ms_t s);
    if (s.dir > 0) return 2'b01;
    if (s.dir < 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_doors(ms_t s);
    logic [2:0] one = 3'b001;
    if (s.door_left > 0) return one << (s.pos / FT);
    return 3'b000;
  endfunction

  always @(posedge CLK) begin
    m <= model_next(m, RST, My_Clock, interior_panel | exterior_panel);
    if (RST) chk_en <= 1'b1;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      total++;
      if (engine !== exp_engine(m) || doors !== exp_doors(m)) begin
        bad++;
        $display("FAIL model_cmp t=%0t got engine=%b doors=%b want engine=%b doors=%b",
                 $time, engine, doors, exp_engine(m), exp_doors(m));
      end
    end
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic check(string name, logic [1:0] e, logic [2:0] d);
    total++;
    if (engine !== e || doors !== d) begin
      bad++;
      $display("FAIL %s got engine=%b doors=%b want engine=%b doors=%b", name, engine, doors, e, d);
    end
  endtask

  task automatic check_bit(string name, bit act, bit exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0b want %0b", name, act, exp);
    end
  endtask

  bit saw_f1, saw_f2, saw_down;

  initial begin
    RST = 1'b1; My_Clock = 1'b1; interior_panel = 3'b101; exterior_panel = 3'b011;
    cyc();
    interior_panel = 3'b110; exterior_panel = 3'b001;
    cyc();
    check("reset_outputs", 2'b00, 3'b000);
    RST = 1'b0; interior_panel = 3'b000; exterior_panel = 3'b000;
    cyc(); cyc();
    check("idle_after_reset", 2'b00, 3'b000);

    // hall call at the current floor
    exterior_panel = 3'b001; cyc();
    check("hall_open_f0", 2'b00, 3'b001);
    exterior_panel = 3'b000; cyc(); cyc();
    check("hall_still_open", 2'b00, 3'b001);
    cyc();
    check("hall_closed", 2'b00, 3'b000);

    // single trip 0 -> 1
    interior_panel = 3'b010; cyc();
    check("up_start", 2'b01, 3'b000);
    interior_panel = 3'b000; cyc();
    check("up_midway", 2'b01, 3'b000);
    cyc();
    check("arrive_f1", 2'b00, 3'b010);
    cyc(); cyc();
    check("f1_door_last", 2'b00, 3'b010);
    cyc();
    check("f1_door_closed", 2'b00, 3'b000);

    // back down to floor 0
    interior_panel = 3'b001; cyc();
    check("down_start", 2'b10, 3'b000);
    interior_panel = 3'b000; cyc(); cyc();
    check("arrive_f0", 2'b00, 3'b001);
    cyc(); cyc(); cyc();
    check("f0_closed", 2'b00, 3'b000);

    // two upward requests: stop at 1, continue to 2, never go down
    interior_panel = 3'b100; exterior_panel = 3'b010; cyc();
    check("multi_start", 2'b01, 3'b000);
    interior_panel = 3'b000; exterior_panel = 3'b000;
    saw_f1 = 1'b0; saw_f2 = 1'b0; saw_down = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (doors == 3'b010) saw_f1 = 1'b1;
      if (doors == 3'b100) saw_f2 = 1'b1;
      if (engine == 2'b10) saw_down = 1'b1;
    end
    check_bit("multi_stop_f1", saw_f1, 1'b1);
    check_bit("multi_stop_f2", saw_f2, 1'b1);
    check_bit("multi_no_down", saw_down, 1'b0);
    check("multi_done", 2'b00, 3'b000);

    // floor 2 -> 0 passing floor 1
    interior_panel = 3'b001; cyc();
    check("long_down_start", 2'b10, 3'b000);
    interior_panel = 3'b000;
    for (int i = 0; i < 11; i++) cyc();
    check("long_down_done", 2'b00, 3'b000);

    // My_Clock freeze while moving
    interior_panel = 3'b010; cyc();
    check("freeze_up_start", 2'b01, 3'b000);
    interior_panel = 3'b000; My_Clock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("freeze_hold", 2'b01, 3'b000);
    end
    My_Clock = 1'b1; cyc();
    check("freeze_tick1", 2'b01, 3'b000);
    cyc();
    check("freeze_arrive", 2'b00, 3'b010);
    cyc(); cyc(); cyc();

    // reset mid-move, then a request for floor 0
    interior_panel = 3'b100; cyc();
    check("pre_reset_move", 2'b01, 3'b000);
    interior_panel = 3'b000; cyc();
    RST = 1'b1; cyc();
    check("reset_mid_move", 2'b00, 3'b000);
    RST = 1'b0; cyc();
    check("idle_post_reset", 2'b00, 3'b000);
    exterior_panel = 3'b001; cyc();
    check("open_after_reset", 2'b00, 3'b001);
    cyc();
    exterior_panel = 3'b000; cyc();
    check("press_door_open", 2'b00, 3'b001);
    cyc();
    check("press_timing", 2'b00, HOLD ? 3'b001 : 3'b000);
    cyc();
    check("no_reopen", 2'b00, 3'b000);

    // repeated floor-1 presses while its door is open
    interior_panel = 3'b010; cyc();
    check("hold_up_start", 2'b01, 3'b000);
    interior_panel = 3'b000; cyc(); cyc();
    check("hold_arrive", 2'b00, 3'b010);
    exterior_panel = 3'b010; cyc(); cyc();
    exterior_panel = 3'b000; cyc();
    check("hold_p1", 2'b00, HOLD ? 3'b010 : 3'b000);
    cyc();
    check("hold_p2", 2'b00, HOLD ? 3'b010 : 3'b000);
    cyc();
    check("hold_p3", 2'b00, 3'b000);

    // current floor and another floor together: door first
    interior_panel = 3'b011; cyc();
    check("door_first", 2'b00, 3'b010);
    interior_panel = 3'b000; cyc(); cyc(); cyc();
    check("door_first_closed", 2'b00, 3'b000);
    cyc();
    check("then_move_down", 2'b10, 3'b000);
    cyc(); cyc();
    check("then_arrive_f0", 2'b00, 3'b001);
    cyc(); cyc(); cyc();
    check("final_idle", 2'b00, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
